// File: rtl/slow_clk_pkg.sv
// slow_clk_pkg: shared types and defaults for the slow-clock receiver.
//   state_t      : debounce FSM states
//   *_DEF        : default parameter values
//   state_level(): debounced level implied by an FSM state
package slow_clk_pkg;

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DEB_CYCLES_DEF  = 16;
   localparam int PER_W_DEF       = 24;

   // Level is high once a rise has been accepted and stays high while a fall is being checked
   function automatic logic state_level(input state_t s);
      logic lvl;
      case (s)
         HIGH, CHK_LOW: lvl = 1'b1;
         LOW, CHK_HIGH: lvl = 1'b0;
         default:       lvl = 1'b0;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/slow_clock_receiver_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous bit into clk.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module sync_chain
   import slow_clk_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stages;

   // Shift the asynchronous bit through the chain; stage 0 is the only one that may go metastable
   always_ff @(posedge clk) begin
      if (reset) begin
         stages <= '0;
      end else begin
         stages <= {stages[STAGES-2:0], d};
      end
   end

   assign q = stages[STAGES-1];

endmodule

// File: rtl/slow_clock_receiver.sv
// slow_clock_receiver: synchronises and debounces a slow asynchronous input,
// emits single-cycle rise/fall strobes and measures the rise-to-rise period.
//   osc_clk      : system clock
//   reset        : synchronous active-high reset
//   async_in     : asynchronous slow input
//   level        : debounced level
//   rise / fall  : one-cycle strobes on accepted edges
//   period       : osc_clk cycles between the last two accepted rises (saturating)
//   period_valid : one-cycle strobe when period updates (coincident with rise)
module slow_clock_receiver
   import slow_clk_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int PER_W       = PER_W_DEF
) (
   input  logic             osc_clk,
   input  logic             reset,
   input  logic             async_in,
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic [PER_W-1:0] period,
   output logic             period_valid
);

   localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_MAX  = '1;
   localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

   logic             sync_q;
   state_t           state;
   logic [DEB_W-1:0] deb_cnt;
   logic [PER_W-1:0] per_cnt;
   logic             seen_rise;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (osc_clk),
      .reset (reset),
      .d     (async_in),
      .q     (sync_q)
   );

   // Debounce FSM, edge strobes and period measurement, all registered together
   always_ff @(posedge osc_clk) begin
      if (reset) begin
         state        <= LOW;
         deb_cnt      <= '0;
         level        <= 1'b0;
         rise         <= 1'b0;
         fall         <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         per_cnt      <= '0;
         seen_rise    <= 1'b0;
      end else begin
         rise         <= 1'b0;
         fall         <= 1'b0;
         period_valid <= 1'b0;
         // Free-running count; the rise branch below overrides it with a restart
         if (per_cnt != PER_MAX) begin
            per_cnt <= per_cnt + PER_ONE;
         end else begin
            per_cnt <= per_cnt;
         end

         case (state)
            LOW: begin
               if (sync_q) begin
                  state   <= CHK_HIGH;
                  deb_cnt <= DEB_W'(1);
               end else begin
                  state   <= LOW;
               end
            end
            CHK_HIGH: begin
               if (!sync_q) begin
                  state <= LOW;
               end else if (deb_cnt == DEB_LAST) begin
                  state     <= HIGH;
                  rise      <= 1'b1;
                  per_cnt   <= PER_ONE;
                  seen_rise <= 1'b1;
                  // The count may already be saturated; report it as-is
                  if (seen_rise) begin
                     period       <= per_cnt;
                     period_valid <= 1'b1;
                  end else begin
                     period       <= period;
                  end
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            HIGH: begin
               if (!sync_q) begin
                  state   <= CHK_LOW;
                  deb_cnt <= DEB_W'(1);
               end else begin
                  state   <= HIGH;
               end
            end
            CHK_LOW: begin
               if (sync_q) begin
                  state <= HIGH;
               end else if (deb_cnt == DEB_LAST) begin
                  state <= LOW;
                  fall  <= 1'b1;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            default: begin
               state   <= LOW;
               deb_cnt <= '0;
            end
         endcase

         // Only completion transitions change the level; glitch returns keep it
         if (state == CHK_HIGH && sync_q && deb_cnt == DEB_LAST) begin
            level <= 1'b1;
         end else if (state == CHK_LOW && !sync_q && deb_cnt == DEB_LAST) begin
            level <= 1'b0;
         end else begin
            level <= state_level(state);
         end
      end
   end

endmodule
